// File: rtl/memory_board_ctrl_if.sv
// Button/board/display bundle for the memory-game board controller.
// The master side drives move/select/board_labels; the slave side (the controller) drives the rest.
interface memory_board_ctrl_if #(
  parameter int NUM_CELLS   = 16,
  parameter int LABEL_W     = 4,
  parameter int NUM_PLAYERS = 2
);
  localparam int CW = $clog2(NUM_CELLS);
  localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int SW = $clog2(NUM_CELLS / 2 + 1);

  logic                         move;
  logic                         select;
  logic [NUM_CELLS*LABEL_W-1:0] board_labels;
  logic [CW-1:0]                cursor;
  logic [LABEL_W-1:0]           cur_label;
  logic [2*NUM_CELLS-1:0]       cell_state;
  logic [PW-1:0]                player;
  logic [NUM_PLAYERS*SW-1:0]    scores;
  logic                         game_over;
  logic [PW-1:0]                winner;
  logic                         tie;
  logic                         timeout;

  modport master (
    output move, select, board_labels,
    input  cursor, cur_label, cell_state, player, scores, game_over, winner, tie, timeout
  );

  modport slave (
    input  move, select, board_labels,
    output cursor, cur_label, cell_state, player, scores, game_over, winner, tie, timeout
  );
endinterface

// File: rtl/memory_board_ctrl.sv
// Board controller for the memory (pairs) game: cursor, card faces, turns, scoring, end of game.
// Optional turn timer enabled by defining TURN_TIMEOUT_EN.
module memory_board_ctrl #(
  parameter int NUM_CELLS      = 16,
  parameter int LABEL_W        = 4,
  parameter int NUM_PLAYERS    = 2,
  parameter int SHOW_CYCLES    = 25000000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input logic                clk,
  input logic                rst,
  memory_board_ctrl_if.slave bus
);
  localparam int CW = $clog2(NUM_CELLS);
  localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int SW = $clog2(NUM_CELLS / 2 + 1);
  localparam int HW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  localparam logic [1:0] ST_HIDDEN  = 2'b00;
  localparam logic [1:0] ST_FACEUP  = 2'b01;
  localparam logic [1:0] ST_MATCHED = 2'b10;

  if (SHOW_CYCLES < 1 || TIMEOUT_CYCLES < 1 || (NUM_CELLS % 2) != 0) begin : g_bad_params
    $error("memory_board_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_PICK1, S_PICK2, S_HOLD, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cursor_q, cursor_d;
  logic [2*NUM_CELLS-1:0]    cells_q, cells_d;
  logic [PW-1:0]             player_q, player_d;
  logic [NUM_PLAYERS*SW-1:0] scores_q, scores_d;
  logic [SW-1:0]             pairs_q, pairs_d;
  logic [CW-1:0]             sel1_q, sel1_d, sel2_q, sel2_d;
  logic [HW-1:0]             hold_q, hold_d;
  logic                      move_q, move_d, select_q, select_d;
  logic                      game_over_q, game_over_d;
  logic [PW-1:0]             winner_q, winner_d;
  logic                      tie_q, tie_d;

  logic          move_ev, sel_ev, cur_hidden, labels_eq, tmo;
  logic [PW-1:0] next_player;
  logic [SW-1:0] best;
  logic [PW-1:0] best_idx;
  int unsigned   best_cnt;

`ifdef TURN_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    cells_d     = cells_q;
    player_d    = player_q;
    scores_d    = scores_q;
    pairs_d     = pairs_q;
    sel1_d      = sel1_q;
    sel2_d      = sel2_q;
    hold_d      = hold_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    tie_d       = tie_q;
    move_d      = bus.move;
    select_d    = bus.select;
    move_ev     = bus.move & ~move_q;
    sel_ev      = bus.select & ~select_q;
    cur_hidden  = (cells_q[{cursor_q, 1'b0} +: 2] == ST_HIDDEN);
    labels_eq   = (bus.board_labels[int'(sel1_q) * LABEL_W +: LABEL_W] ==
                   bus.board_labels[int'(sel2_q) * LABEL_W +: LABEL_W]);
    next_player = (player_q == PW'(NUM_PLAYERS - 1)) ? '0 : player_q + PW'(1);
`ifdef TURN_TIMEOUT_EN
    tmo = (state_q == S_PICK1 || state_q == S_PICK2) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
    tmo = 1'b0;
`endif

    // Picks below use cursor_q, so a same-cycle move still selects the pre-move cell.
    if (move_ev && state_q != S_DONE)
      cursor_d = (cursor_q == CW'(NUM_CELLS - 1)) ? '0 : cursor_q + CW'(1);

    if (tmo) begin
      if (state_q == S_PICK2) cells_d[{sel1_q, 1'b0} +: 2] = ST_HIDDEN;
      player_d = next_player;
      state_d  = S_PICK1;
    end else begin
      case (state_q)
        S_PICK1: if (sel_ev && cur_hidden) begin
          cells_d[{cursor_q, 1'b0} +: 2] = ST_FACEUP;
          sel1_d  = cursor_q;
          state_d = S_PICK2;
        end
        S_PICK2: if (sel_ev && cur_hidden) begin
          cells_d[{cursor_q, 1'b0} +: 2] = ST_FACEUP;
          sel2_d  = cursor_q;
          hold_d  = HW'(SHOW_CYCLES - 1);
          state_d = S_HOLD;
        end
        S_HOLD: if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end else if (labels_eq) begin
          cells_d[{sel1_q, 1'b0} +: 2] = ST_MATCHED;
          cells_d[{sel2_q, 1'b0} +: 2] = ST_MATCHED;
          scores_d[int'(player_q) * SW +: SW] = scores_q[int'(player_q) * SW +: SW] + SW'(1);
          pairs_d = pairs_q - SW'(1);
          if (pairs_q == SW'(1)) begin
            state_d     = S_DONE;
            game_over_d = 1'b1;
          end else begin
            state_d = S_PICK1;
          end
        end else begin
          cells_d[{sel1_q, 1'b0} +: 2] = ST_HIDDEN;
          cells_d[{sel2_q, 1'b0} +: 2] = ST_HIDDEN;
          player_d = next_player;
          state_d  = S_PICK1;
        end
        default: ;
      endcase
    end

    // Winner/tie are evaluated on the final scores and latched only on entry to DONE.
    best     = '0;
    best_idx = '0;
    best_cnt = 0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      if (scores_d[p * SW +: SW] > best) begin
        best     = scores_d[p * SW +: SW];
        best_idx = PW'(p);
      end
    end
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      if (scores_d[p * SW +: SW] == best) best_cnt = best_cnt + 1;
    end
    if (state_q != S_DONE && state_d == S_DONE) begin
      winner_d = best_idx;
      tie_d    = (best_cnt > 1);
    end

`ifdef TURN_TIMEOUT_EN
    timeout_d = tmo;
    timer_d   = timer_q;
    if (state_q == S_PICK1 || state_q == S_PICK2) timer_d = timer_q + TW'(1);
    if (tmo || (state_d == S_PICK1 && state_q != S_PICK1) ||
        (state_q == S_PICK1 && state_d == S_PICK2))
      timer_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_PICK1;
      cursor_q    <= '0;
      cells_q     <= '0;
      player_q    <= '0;
      scores_q    <= '0;
      pairs_q     <= SW'(NUM_CELLS / 2);
      sel1_q      <= '0;
      sel2_q      <= '0;
      hold_q      <= '0;
      move_q      <= 1'b0;
      select_q    <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= '0;
      tie_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      cells_q     <= cells_d;
      player_q    <= player_d;
      scores_q    <= scores_d;
      pairs_q     <= pairs_d;
      sel1_q      <= sel1_d;
      sel2_q      <= sel2_d;
      hold_q      <= hold_d;
      move_q      <= move_d;
      select_q    <= select_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      tie_q       <= tie_d;
    end
  end

`ifdef TURN_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.cursor     = cursor_q;
  assign bus.cur_label  = bus.board_labels[int'(cursor_q) * LABEL_W +: LABEL_W];
  assign bus.cell_state = cells_q;
  assign bus.player     = player_q;
  assign bus.scores     = scores_q;
  assign bus.game_over  = game_over_q;
  assign bus.winner     = winner_q;
  assign bus.tie        = tie_q;
endmodule

// File: tb/tb_memory_board_ctrl.sv
// Directed bench for memory_board_ctrl: a small board/score model feeds a scoreboard of
// expected post-resolve states, compared when each HOLD phase resolves.
module tb_memory_board_ctrl;
  localparam int NC   = 16;
  localparam int LW   = 4;
  localparam int NP   = 2;
  localparam int SHOW = 4;
  localparam int TMO  = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  memory_board_ctrl_if #(.NUM_CELLS(NC), .LABEL_W(LW), .NUM_PLAYERS(NP)) bus ();

  memory_board_ctrl #(
    .NUM_CELLS(NC), .LABEL_W(LW), .NUM_PLAYERS(NP),
    .SHOW_CYCLES(SHOW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [2*NC-1:0] cells;
    logic [NP*4-1:0] scores;
    logic            player;
  } exp_t;

  exp_t sbq[$];
  int   lab[NC] = '{1, 3, 2, 4, 5, 6, 7, 8, 6, 3, 7, 4, 8, 1, 5, 2};
  int   pa[8]   = '{0, 2, 1, 3, 4, 5, 6, 7};
  int   pb[8]   = '{13, 15, 9, 11, 14, 8, 10, 12};
  int   mc[NC];
  int   ms[NP];
  int   mp, mcur, mpairs;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2*NC-1:0] cells_vec();
    logic [2*NC-1:0] v;
    for (int i = 0; i < NC; i++) v[2*i +: 2] = mc[i][1:0];
    return v;
  endfunction

  function automatic logic [NP*4-1:0] scores_vec();
    logic [NP*4-1:0] v;
    for (int p = 0; p < NP; p++) v[4*p +: 4] = ms[p][3:0];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) mc[i] = 0;
    for (int p = 0; p < NP; p++) ms[p] = 0;
    mp = 0; mcur = 0; mpairs = NC / 2;
  endtask

  task automatic do_reset();
    bus.move = 1'b0; bus.select = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
  endtask

  task automatic pulse_move();
    bus.move = 1'b1; tick();
    bus.move = 1'b0; tick();
    mcur = (mcur + 1) % NC;
  endtask

  task automatic pulse_sel();
    bus.select = 1'b1; tick();
    bus.select = 1'b0; tick();
  endtask

  task automatic goto_cell(input int t);
    while (mcur != t) pulse_move();
  endtask

  task automatic sb_pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      $error("FAIL sb_empty: got no expected entry, required one");
    end else begin
      e = sbq.pop_front();
      chk("res_cells", bus.cell_state, e.cells);
      chk("res_scores", bus.scores, e.scores);
      chk("res_player", bus.player, e.player);
    end
  endtask

  // Called one edge after the second select edge; resolve lands SHOW edges after that select.
  task automatic resolve(input int a, input int b);
    exp_t e;
    repeat (SHOW - 2) tick();
    chk("hold_faceup", bus.cell_state, cells_vec());
    if (lab[a] == lab[b]) begin
      mc[a] = 2; mc[b] = 2; ms[mp]++; mpairs--;
    end else begin
      mc[a] = 0; mc[b] = 0; mp = (mp + 1) % NP;
    end
    e.cells = cells_vec(); e.scores = scores_vec(); e.player = mp[0];
    sbq.push_back(e);
    tick();
    sb_pop_check();
  endtask

  task automatic pick_pair(input int a, input int b);
    goto_cell(a); pulse_sel(); mc[a] = 1;
    goto_cell(b); pulse_sel(); mc[b] = 1;
    resolve(a, b);
  endtask

  task automatic check_end();
    int best, w, cnt;
    best = -1; w = 0; cnt = 0;
    for (int p = 0; p < NP; p++) if (ms[p] > best) begin best = ms[p]; w = p; end
    for (int p = 0; p < NP; p++) if (ms[p] == best) cnt++;
    chk("game_over", bus.game_over, 1);
    chk("winner", bus.winner, w);
    chk("tie", bus.tie, (cnt > 1) ? 1 : 0);
  endtask

  initial begin
    int n;
    bus.move = 1'b0; bus.select = 1'b0;
    for (int i = 0; i < NC; i++) bus.board_labels[i*LW +: LW] = lab[i][LW-1:0];
    model_reset();
    #2;
    chk("rst_cursor", bus.cursor, 0);
    chk("rst_cells", bus.cell_state, 0);
    chk("rst_player", bus.player, 0);
    chk("rst_scores", bus.scores, 0);
    chk("rst_game_over", bus.game_over, 0);
    chk("rst_winner", bus.winner, 0);
    chk("rst_tie", bus.tie, 0);
    chk("rst_timeout", bus.timeout, 0);
    tick();
    rst = 1'b1;

`ifdef TURN_TIMEOUT_EN
    // Timer restarts on the accepted first pick; expiry is 20 edges later.
    pulse_sel(); mc[0] = 1;
    n = 0;
    while (bus.timeout !== 1'b1 && n < 40) begin tick(); n++; end
    chk("tmo_latency", n, TMO - 1);
    chk("tmo_cells", bus.cell_state, 0);
    chk("tmo_player", bus.player, 1);
    tick();
    chk("tmo_pulse_end", bus.timeout, 0);
`else
    // Cursor walk with wrap and label lookup.
    for (int k = 0; k < 17; k++) begin
      pulse_move();
      chk("cursor_walk", bus.cursor, mcur);
      chk("cur_label", bus.cur_label, lab[mcur]);
    end
    bus.move = 1'b1;
    repeat (10) tick();
    bus.move = 1'b0; tick();
    mcur = (mcur + 1) % NC;
    chk("move_held", bus.cursor, mcur);

    // Matching pair by player 0.
    do_reset();
    pick_pair(0, 13);

    // Two mismatches: player rotates 0 -> 1 -> 0.
    do_reset();
    pick_pair(1, 2);
    pick_pair(3, 4);
    chk("no_timeout", bus.timeout, 0);

    // Ignored selects in PICK2, then same-cycle move+select.
    do_reset();
    pick_pair(0, 13);
    goto_cell(1); pulse_sel(); mc[1] = 1;
    pulse_sel();
    chk("ign_same_cell", bus.cell_state, cells_vec());
    goto_cell(0); pulse_sel();
    chk("ign_matched", bus.cell_state, cells_vec());
    goto_cell(9);
    bus.move = 1'b1; bus.select = 1'b1; tick();
    bus.move = 1'b0; bus.select = 1'b0; tick();
    mcur = 10; mc[9] = 1;
    chk("mv_sel_cursor", bus.cursor, mcur);
    resolve(1, 9);

    // Player 0 clears the board.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      pick_pair(pa[k], pb[k]);
      if (k < 7) chk("not_over", bus.game_over, 0);
    end
    check_end();
    n = mcur;
    bus.move = 1'b1; tick(); bus.move = 1'b0; tick();
    chk("done_frozen", bus.cursor, n);
    pulse_sel();
    chk("done_cells", bus.cell_state, cells_vec());

    // 4-4 split: tie, winner is the lower index.
    do_reset();
    for (int k = 0; k < 4; k++) pick_pair(pa[k], pb[k]);
    pick_pair(4, 5);
    for (int k = 4; k < 8; k++) pick_pair(pa[k], pb[k]);
    check_end();

    // Reset asserted in HOLD discards the turn.
    do_reset();
    goto_cell(0); pulse_sel();
    goto_cell(13); pulse_sel();
    tick();
    rst = 1'b0;
    #1;
    chk("hold_rst_cells", bus.cell_state, 0);
    chk("hold_rst_cursor", bus.cursor, 0);
    chk("hold_rst_scores", bus.scores, 0);
    chk("hold_rst_over", bus.game_over, 0);
    tick();
    rst = 1'b1;
    model_reset();
    repeat (SHOW + 2) tick();
    chk("post_rst_cells", bus.cell_state, 0);
    chk("post_rst_player", bus.player, 0);
    chk("post_rst_timeout", bus.timeout, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
